// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-requester round-robin arbiter/sequencer in front of a single-port data
//   memory. Requester 0 is the core load/store path and requester 1 is DMA/debug.
//   Each accepted request runs exactly one memory access. Every access returns
//   exactly one response to its owner.
//
// Handshake semantics (request and response channels alike): a transfer happens
//   on the rising clk edge where valid and ready are both high. The producer may
//   change or drop valid at any time before that edge; the arbiter never relies
//   on valid staying high. Response payloads (rdata, rsp_err) stay stable while
//   rsp_valid is high and rsp_ready is low.
//
// Ports
//   clk, reset               rising-edge clock, asynchronous active-high reset
//   mN_req_valid/ready       N=0,1 request handshake (ready is combinational)
//   mN_we, mN_addr, mN_wdata request payload (byte address, word = addr[ADDR_W-1:2])
//   mN_rsp_valid/ready       response handshake
//   mN_rdata, mN_rsp_err     response payload (rdata is 0 for writes)
//   mem_we/addr/din/dout     single-port memory, dout combinational from addr
//   dbg_state                FSM state (0=IDLE, 1=ACCESS, 2=RESP)
//   dbg_oob                  latched access address is beyond MEM_WORDS
//
// Configuration macro
//   ADDR_CHECK_EN : reject accesses whose word index >= MEM_WORDS (no write,
//                   rdata=0, rsp_err=1). Undefined: no check, rsp_err stays 0
//                   and out-of-range addresses alias in memory.
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req_valid,
    output logic              m0_req_ready,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_rsp_valid,
    input  logic              m0_rsp_ready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rsp_err,
    input  logic              m1_req_valid,
    output logic              m1_req_ready,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_rsp_valid,
    input  logic              m1_rsp_ready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_rsp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [1:0]        dbg_state,
    output logic              dbg_oob
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [ADDR_W-3:0] MEM_WORDS_IDX = (ADDR_W-2)'(MEM_WORDS);

    state_t            state;
    logic              last_grant;   // 1: m1 was granted last, so m0 wins a tie
    logic              owner;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              pick1;
    logic              out_of_range;
    logic              reject;

    // m1 wins when it is the only requester, or on a tie when m0 was served last.
    assign pick1 = m1_req_valid & (~m0_req_valid | ~last_grant);

    assign out_of_range = (lat_addr[ADDR_W-1:2] >= MEM_WORDS_IDX);

`ifdef ADDR_CHECK_EN
    assign reject = out_of_range;
`else
    assign reject = 1'b0;
`endif

    // Ready is held low during reset so nothing can be accepted while aborting.
    assign m0_req_ready = ~reset & (state == IDLE) & m0_req_valid & ~pick1;
    assign m1_req_ready = ~reset & (state == IDLE) & pick1;

    assign m0_rsp_valid = (state == RESP) & ~owner;
    assign m1_rsp_valid = (state == RESP) & owner;
    assign m0_rdata     = rdata_q;
    assign m1_rdata     = rdata_q;
    assign m0_rsp_err   = err_q;
    assign m1_rsp_err   = err_q;

    // Address/data come straight from the latch, so they hold their last value
    // outside ACCESS; the write strobe exists only in ACCESS.
    assign mem_we   = (state == ACCESS) & lat_we & ~reject;
    assign mem_addr = lat_addr;
    assign mem_din  = lat_wdata;

    assign dbg_state = state;
    assign dbg_oob   = out_of_range;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req_valid | m1_req_valid) begin
                        owner      <= pick1;
                        last_grant <= pick1;
                        lat_we     <= pick1 ? m1_we    : m0_we;
                        lat_addr   <= pick1 ? m1_addr  : m0_addr;
                        lat_wdata  <= pick1 ? m1_wdata : m0_wdata;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    rdata_q <= (lat_we | reject) ? '0 : mem_dout;
                    err_q   <= reject;
                    state   <= RESP;
                end
                RESP: begin
                    if (owner ? m1_rsp_ready : m0_rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        m0_req_valid = 0, m0_we = 0, m0_rsp_ready;
    logic [31:0] m0_addr = 0, m0_wdata = 0;
    logic        m1_req_valid = 0, m1_we = 0, m1_rsp_ready;
    logic [31:0] m1_addr = 0, m1_wdata = 0;
    logic        m0_req_ready, m0_rsp_valid, m0_rsp_err;
    logic        m1_req_ready, m1_rsp_valid, m1_rsp_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_din, mem_dout;
    logic [1:0]  dbg_state;
    logic        dbg_oob;
    logic        rsp_rdy0 = 1'b1, rsp_rdy1 = 1'b1;

    assign m0_rsp_ready = rsp_rdy0;
    assign m1_rsp_ready = rsp_rdy1;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_WORDS(64)) dut (
        .clk(clk), .reset(reset),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_we(m0_we),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rsp_valid(m0_rsp_valid),
        .m0_rsp_ready(m0_rsp_ready), .m0_rdata(m0_rdata), .m0_rsp_err(m0_rsp_err),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_we(m1_we),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rsp_valid(m1_rsp_valid),
        .m1_rsp_ready(m1_rsp_ready), .m1_rdata(m1_rdata), .m1_rsp_err(m1_rsp_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .dbg_state(dbg_state), .dbg_oob(dbg_oob)
    );

    // 64-word memory model; addresses alias on word index modulo 64.
    logic [31:0] mem [0:63];
    initial for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    assign mem_dout = mem[mem_addr[7:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_din;

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [32:0] exp_q0[$];   // {rdata, err}
    logic [32:0] exp_q1[$];
    int gnt_who[$];
    int gnt_cyc[$];

    localparam logic [31:0] DA = 32'hA0A0_A0A0;
    localparam logic [31:0] DB = 32'hB0B0_B0B0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: responses, grants and one-hot invariant, sampled on negedge.
    always @(negedge clk) begin
        if (!reset) begin
            logic [32:0] e;
            if (m0_rsp_valid && rsp_rdy0) begin
                if (exp_q0.size() == 0) check("m0_unexpected_rsp", 1, 0);
                else begin
                    e = exp_q0.pop_front();
                    check("m0_rsp", {m0_rdata, m0_rsp_err}, e);
                end
            end
            if (m1_rsp_valid && rsp_rdy1) begin
                if (exp_q1.size() == 0) check("m1_unexpected_rsp", 1, 0);
                else begin
                    e = exp_q1.pop_front();
                    check("m1_rsp", {m1_rdata, m1_rsp_err}, e);
                end
            end
            if (m0_req_valid && m0_req_ready) begin gnt_who.push_back(0); gnt_cyc.push_back(cyc); end
            if (m1_req_valid && m1_req_ready) begin gnt_who.push_back(1); gnt_cyc.push_back(cyc); end
            check("onehot", 32'($countones({m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid})) <= 1, 1);
            if (m0_req_ready || m1_req_ready) check("ready_only_idle", dbg_state, 0);
        end
    end

    // ---------------- driver ----------------
    task automatic set_req(input int n, input logic v, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
        if (n == 0) begin m0_req_valid = v; m0_we = we; m0_addr = addr; m0_wdata = wdata; end
        else        begin m1_req_valid = v; m1_we = we; m1_addr = addr; m1_wdata = wdata; end
    endtask

    // Issue one request, push its expected response, then check the access
    // cycle (T+1) and the first response cycle (T+2).
    task automatic issue(input int n, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err, input logic exp_mem_we);
        bit got = 0;
        if (n == 0) exp_q0.push_back({exp_rdata, exp_err});
        else        exp_q1.push_back({exp_rdata, exp_err});
        @(posedge clk); #1;
        set_req(n, 1'b1, we, addr, wdata);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if ((n == 0) ? m0_req_ready : m1_req_ready) begin got = 1; break; end
        end
        if (!got) begin
            check("req_timeout", 0, 1);
            set_req(n, 1'b0, 1'b0, 32'h0, 32'h0);
            return;
        end
        @(posedge clk); #1;
        set_req(n, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("access_mem_we", mem_we, exp_mem_we);
        check("access_mem_addr", mem_addr, addr);
        if (exp_mem_we) check("access_mem_din", mem_din, wdata);
        @(negedge clk);
        check("rsp_latency", (n == 0) ? m0_rsp_valid : m1_rsp_valid, 1);
        check("mem_we_after_access", mem_we, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        // Reset state with requests pending: nothing may be accepted.
        m0_req_valid = 1; m1_req_valid = 1;
        repeat (2) @(negedge clk);
        check("rst_m0_req_ready", m0_req_ready, 0);
        check("rst_m1_req_ready", m1_req_ready, 0);
        check("rst_rsp_valid", {m0_rsp_valid, m1_rsp_valid}, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_rdata", m0_rdata, 0);
        m0_req_valid = 0; m1_req_valid = 0;
        @(posedge clk); #1 reset = 0;

        // Test 2: both requesting from reset -> m0,m1,m0,m1
        gnt_who.delete(); gnt_cyc.delete();
        fork
            begin
                issue(0, 1, 32'h4, DA, 32'h0, 0, 1);
                issue(0, 0, 32'h8, 32'h0, DB, 0, 0);
            end
            begin
                issue(1, 1, 32'h8, DB, 32'h0, 0, 1);
                issue(1, 0, 32'h4, 32'h0, DA, 0, 0);
            end
        join
        check("rr_count", gnt_who.size(), 4);
        if (gnt_who.size() == 4) begin
            check("rr_0", gnt_who[0], 0);
            check("rr_1", gnt_who[1], 1);
            check("rr_2", gnt_who[2], 0);
            check("rr_3", gnt_who[3], 1);
        end

        // Test 1: m0 write then read back 0x10
        issue(0, 1, 32'h10, 32'hDEAD_BEEF, 32'h0, 0, 1);
        issue(0, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 0);
        check("mem4_written", mem[4], 32'hDEAD_BEEF);

        // Test 3: m1 read stalled 5 cycles while m0 waits
        @(posedge clk); #1 rsp_rdy1 = 0;
        fork
            begin
                issue(1, 0, 32'h8, 32'h0, DB, 0, 0);
                repeat (5) begin
                    @(negedge clk);
                    check("hold_m1_valid", m1_rsp_valid, 1);
                    check("hold_m1_rdata", m1_rdata, DB);
                    check("hold_no_m0_grant", m0_req_ready, 0);
                end
                @(posedge clk); #1 rsp_rdy1 = 1;
            end
            begin
                repeat (2) @(posedge clk);
                issue(0, 0, 32'h4, 32'h0, DA, 0, 0);
            end
        join

        // Test 6: back-to-back m0 reads, one every 3 cycles
        gnt_who.delete(); gnt_cyc.delete();
        issue(0, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 0);
        issue(0, 0, 32'h4, 32'h0, DA, 0, 0);
        issue(0, 0, 32'h8, 32'h0, DB, 0, 0);
        check("b2b_count", gnt_cyc.size(), 3);
        if (gnt_cyc.size() == 3) begin
            check("b2b_gap1", gnt_cyc[1] - gnt_cyc[0], 3);
            check("b2b_gap2", gnt_cyc[2] - gnt_cyc[1], 3);
        end

        // Test 4: reset during ACCESS of a write to 0x20
        begin
            bit got = 0;
            @(posedge clk); #1 set_req(0, 1'b1, 1'b1, 32'h20, 32'hCAFE_F00D);
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (m0_req_ready) begin got = 1; break; end
            end
            check("abort_accepted", got, 1);
            @(posedge clk); #1 set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
            reset = 1;
            @(negedge clk);
            check("abort_mem_we", mem_we, 0);
            check("abort_mem_addr", mem_addr, 0);
            check("abort_mem_din", mem_din, 0);
            check("abort_rsp_valid", {m0_rsp_valid, m1_rsp_valid}, 0);
            check("abort_rdata", m0_rdata, 0);
            @(posedge clk); #1 reset = 0;
            repeat (4) @(negedge clk);
            check("abort_mem8", mem[8], 32'h1000_0008);
            issue(0, 0, 32'h20, 32'h0, 32'h1000_0008, 0, 0);
        end

        // Test 5: write to word 64 (0x100)
`ifdef ADDR_CHECK_EN
        issue(0, 1, 32'h100, 32'h55AA_55AA, 32'h0, 1, 0);
        issue(0, 0, 32'h0, 32'h0, 32'h1000_0000, 0, 0);
`else
        issue(0, 1, 32'h100, 32'h55AA_55AA, 32'h0, 0, 1);
        issue(0, 0, 32'h0, 32'h0, 32'h55AA_55AA, 0, 0);
`endif

        // Drain and report
        for (int i = 0; i < 20; i++) begin
            if (exp_q0.size() == 0 && exp_q1.size() == 0) break;
            @(negedge clk);
        end
        check("drain_q0", exp_q0.size(), 0);
        check("drain_q1", exp_q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule
